// File: rtl/ray_pkg.sv
// Shared ray-casting types.
// Holds the distance/wall-id widths, the no-hit sentinel and the matching
// typedefs. Intersection consumers and the column renderer import this too.
package ray_pkg;

    localparam int DIST_W = 19;
    localparam int ID_W   = 6;

    typedef logic [DIST_W-1:0] dist_t;
    typedef logic [ID_W-1:0]   wall_id_t;

    // All-ones distance means "no hit / behind origin"; it compares as
    // infinity under a plain unsigned compare.
    localparam dist_t NO_HIT = '1;

endpackage

// File: rtl/nearest_wall_select.sv
// nearest_wall_select
// Reduces a framed stream of per-wall candidate distances to the nearest hit
// for each ray and hands one result per ray to the column renderer.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           candidate handshake (in_ready = not holding a result)
//   in_dist, in_wall_id         candidate distance (all-ones = no hit) and wall index
//   in_first, in_last           ray framing flags
//   out_valid/out_ready         result handshake
//   out_dist, out_wall_id       nearest distance and its wall (wall 0 if no hit)
//   out_hit                     result is a real hit
//   out_count                   candidates accepted for the ray, saturating
module nearest_wall_select
    import ray_pkg::*;
#(
    parameter int DIST_W = ray_pkg::DIST_W,
    parameter int ID_W   = ray_pkg::ID_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIST_W-1:0] in_dist,
    input  logic [ID_W-1:0]   in_wall_id,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIST_W-1:0] out_dist,
    output logic [ID_W-1:0]   out_wall_id,
    output logic              out_hit,
    output logic [CNT_W-1:0]  out_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam logic [DIST_W-1:0] DIST_INF = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_e            state_q, state_d;
    logic [DIST_W-1:0] best_dist_q, best_dist_d;
    logic [ID_W-1:0]   best_id_q, best_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DIST_W-1:0] out_dist_q, out_dist_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

    logic              accept;
    logic              open_ray;
    logic [DIST_W-1:0] nb_dist;
    logic [ID_W-1:0]   nb_id;
    logic [CNT_W-1:0]  nb_cnt;

    // in_ready depends only on registered state, so downstream out_ready
    // never reaches the upstream handshake combinationally.
    assign in_ready = (state_q != ST_OUT);
    assign accept   = in_valid && in_ready;
    // A beat arriving with no ray open starts one even without in_first.
    assign open_ray = in_first || (state_q == ST_IDLE);

    // Running minimum as it stands after the current beat.
    always_comb begin
        nb_dist = best_dist_q;
        nb_id   = best_id_q;
        nb_cnt  = cnt_q;
        if (open_ray) begin
            nb_dist = in_dist;
            nb_id   = in_wall_id;
            nb_cnt  = CNT_W'(1);
        end else begin
            nb_cnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            // Strict compare: ties keep the earlier wall, and the sentinel
            // can never displace a real hit.
            if (in_dist < best_dist_q) begin
                nb_dist = in_dist;
                nb_id   = in_wall_id;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        best_dist_d = best_dist_q;
        best_id_d   = best_id_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_dist_d  = out_dist_q;
        out_id_d    = out_id_q;
        out_cnt_d   = out_cnt_q;

        if (accept) begin
            best_dist_d = nb_dist;
            best_id_d   = nb_id;
            cnt_d       = nb_cnt;
            if (in_last) begin
                state_d     = ST_OUT;
                out_valid_d = 1'b1;
                out_dist_d  = nb_dist;
                out_id_d    = (nb_dist == DIST_INF) ? '0 : nb_id;
                out_cnt_d   = nb_cnt;
            end else begin
                state_d = ST_ACC;
            end
        end else if (state_q == ST_OUT && out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            best_dist_q <= DIST_INF;
            best_id_q   <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_dist_q  <= DIST_INF;
            out_id_q    <= '0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            best_dist_q <= best_dist_d;
            best_id_q   <= best_id_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_dist_q  <= out_dist_d;
            out_id_q    <= out_id_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_dist    = out_dist_q;
    assign out_wall_id = out_id_q;
    assign out_hit     = (out_dist_q != DIST_INF);
    assign out_count   = out_cnt_q;

endmodule

// File: tb/tb_nearest_wall_select.sv
module tb_nearest_wall_select;
    localparam int DW = 19;
    localparam int IW = 6;
    localparam int CW = 8;
    localparam logic [DW-1:0] NH = 19'h7FFFF;

    logic          clk, rst_n;
    logic          in_valid, in_ready, in_first, in_last;
    logic [DW-1:0] in_dist;
    logic [IW-1:0] in_wall_id;
    logic          out_valid, out_ready, out_hit;
    logic [DW-1:0] out_dist;
    logic [IW-1:0] out_wall_id;
    logic [CW-1:0] out_count;

    int n_cmp = 0;
    int n_err = 0;

    // Candidates of the currently open ray, as the spec defines it.
    logic [DW-1:0] q_d[$];
    logic [IW-1:0] q_i[$];

    nearest_wall_select #(.DIST_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dist(in_dist), .in_wall_id(in_wall_id),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dist(out_dist), .out_wall_id(out_wall_id),
        .out_hit(out_hit), .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: nearest = first candidate with the smallest distance,
    // count = number of candidates clipped at 255.
    task automatic ref_result(output logic [DW-1:0] d, output logic [IW-1:0] id,
                              output logic [CW-1:0] c);
        d = NH; id = '0;
        for (int k = 0; k < q_d.size(); k++)
            if (k == 0 || q_d[k] < d) begin d = q_d[k]; id = q_i[k]; end
        if (d == NH) id = '0;
        c = (q_d.size() > 255) ? 8'd255 : CW'(q_d.size());
    endtask

    // Present one beat (after optional idle gap with junk data) and wait
    // until it is accepted. Returns at posedge+1.
    task automatic beat(input logic [DW-1:0] d, input logic [IW-1:0] id,
                        input logic first, input logic last, input int gap);
        bit ok;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0; in_dist = DW'($urandom); in_wall_id = IW'($urandom);
            in_first = 1'($urandom); in_last = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_dist = d; in_wall_id = id; in_first = first; in_last = last;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            $display("FAIL beat_accept in_ready stuck low, got %0b exp 1", in_ready);
            $fatal(1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        if (first) begin q_d.delete(); q_i.delete(); end
        q_d.push_back(d); q_i.push_back(id);
    endtask

    // Called right after the last beat was accepted.
    task automatic check_result(input string name, input int stall);
        logic [DW-1:0] ed; logic [IW-1:0] ei; logic [CW-1:0] ec;
        ref_result(ed, ei, ec);
        out_ready = (stall == 0);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s out_valid got %0b exp 1", name, out_valid); end
        n_cmp++; if (out_dist !== ed) begin n_err++; $display("FAIL %s out_dist got %0d exp %0d", name, out_dist, ed); end
        n_cmp++; if (out_wall_id !== ei) begin n_err++; $display("FAIL %s out_wall_id got %0d exp %0d", name, out_wall_id, ei); end
        n_cmp++; if (out_hit !== (ed != NH)) begin n_err++; $display("FAIL %s out_hit got %0b exp %0b", name, out_hit, ed != NH); end
        n_cmp++; if (out_count !== ec) begin n_err++; $display("FAIL %s out_count got %0d exp %0d", name, out_count, ec); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL %s in_ready_out got %0b exp 0", name, in_ready); end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_dist !== ed || out_wall_id !== ei || in_ready !== 1'b0)
                begin n_err++; $display("FAIL %s hold v=%0b d=%0d id=%0d rdy=%0b exp 1/%0d/%0d/0", name, out_valid, out_dist, out_wall_id, in_ready, ed, ei); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s drop got %0b exp 0", name, out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s in_ready_after got %0b exp 1", name, in_ready); end
        n_cmp++; if (out_dist !== ed || out_count !== ec) begin n_err++; $display("FAIL %s retain got %0d/%0d exp %0d/%0d", name, out_dist, out_count, ed, ec); end
        q_d.delete(); q_i.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_first = 0; in_last = 0; in_dist = '0; in_wall_id = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %0b exp 0", out_valid); end
        n_cmp++; if (out_dist !== NH) begin n_err++; $display("FAIL reset out_dist got %0h exp %0h", out_dist, NH); end
        n_cmp++; if (out_wall_id !== '0 || out_hit !== 1'b0 || out_count !== '0)
            begin n_err++; $display("FAIL reset misc got id=%0d hit=%0b cnt=%0d exp 0/0/0", out_wall_id, out_hit, out_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %0b exp 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        beat(300, 1, 1, 0, 0); beat(120, 2, 0, 0, 0); beat(NH, 3, 0, 0, 0); beat(500, 4, 0, 1, 0);
        check_result("basic", 0);
    endtask

    task automatic test_tie();
        beat(200, 5, 1, 0, 0); beat(200, 9, 0, 1, 0);
        check_result("tie", 0);
    endtask

    task automatic test_all_nohit();
        beat(NH, 7, 1, 0, 0); beat(NH, 8, 0, 0, 1); beat(NH, 9, 0, 1, 0);
        check_result("nohit", 0);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ed; logic [IW-1:0] ei; logic [CW-1:0] ec;
        beat(400, 10, 1, 0, 0); beat(350, 11, 0, 1, 0);
        ref_result(ed, ei, ec);
        out_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0; in_dist = 60; in_wall_id = 3;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_dist !== ed || out_wall_id !== ei || out_count !== ec)
                begin n_err++; $display("FAIL bp_hold rdy=%0b v=%0b d=%0d id=%0d c=%0d exp 0/1/%0d/%0d/%0d", in_ready, out_valid, out_dist, out_wall_id, out_count, ed, ei, ec); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop got %0b exp 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_next_accept in_ready got %0b exp 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0;
        q_d.delete(); q_i.delete(); q_d.push_back(60); q_i.push_back(3);
        beat(70, 4, 0, 1, 0);
        check_result("bp_next", 0);
    endtask

    task automatic test_single_restart();
        beat(77, 12, 1, 1, 0);
        check_result("single", 0);
        beat(10, 1, 1, 0, 0); beat(20, 2, 0, 0, 0); beat(50, 3, 1, 0, 0); beat(40, 4, 0, 1, 0);
        check_result("restart", 0);
    endtask

    task automatic test_reset_midray();
        beat(5, 7, 1, 0, 1);
        rst_n = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0 || out_dist !== NH || out_count !== '0)
            begin n_err++; $display("FAIL midrst v=%0b d=%0h c=%0d exp 0/%0h/0", out_valid, out_dist, out_count, NH); end
        @(negedge clk); rst_n = 1'b1;
        q_d.delete(); q_i.delete();
        @(posedge clk); #1;
        beat(90, 1, 0, 0, 0); beat(80, 2, 0, 1, 0);
        check_result("after_rst", 0);
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 300; k++)
            beat((k == 150) ? DW'(999) : DW'(1000 + $urandom_range(0, 5000)), IW'(k), k == 0, k == 299, 0);
        check_result("saturate", 1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int len;
            bit pre;
            pre = ($urandom_range(0, 3) == 0);
            if (pre) for (int k = 0; k < $urandom_range(1, 3); k++)
                beat(DW'($urandom_range(0, 20)), IW'($urandom), k == 0, 1'b0, $urandom_range(0, 2));
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                logic [DW-1:0] d;
                case ($urandom_range(0, 3))
                    0: d = NH;
                    1: d = DW'($urandom_range(0, 15));
                    default: d = DW'($urandom_range(0, 262143));
                endcase
                beat(d, IW'($urandom), (k == 0) ? (pre ? 1'b1 : 1'($urandom)) : 1'b0, k == len - 1, $urandom_range(0, 2));
            end
            check_result("random", $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_all_nohit();
        test_backpressure();
        test_single_restart();
        test_reset_midray();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
